// File: rtl/lia_multich_csr.sv
`default_nettype none
// ============================================================================
// Module   : lia_multich_csr
// Purpose  : Avalon-MM control/status bank for NCH lock-in channels. Holds
//            shadow and active phase increment/offset per channel with an
//            atomic commit, either immediate or aligned to sync_in. Captures
//            a coherent all-channel X/Y snapshot with done/timeout status and
//            a level interrupt.
// Ports    : clk_clk, reset_reset        clock, synchronous active-high reset
//            avs_address/read/write/      Avalon-MM slave, no waitrequest,
//            writedata/readdata/          read data registered one cycle
//            readdatavalid                after avs_read
//            sync_in                      commit alignment pulse
//            lia_x, lia_y, lia_valid      per-channel lock-in results
//            phase_incr, phase_offs       active per-channel phase settings
//            gain_ctrl                    gain setting (not shadowed)
//            commit_pulse                 1-cycle pulse on active update
//            irq                          irq_en & (snap_done | snap_tmo)
// Revision : 1.0  initial release
// ============================================================================
module lia_multich_csr #(
  parameter int NCH         = 8,
  parameter int PHASE_W     = 20,
  parameter int XY_W        = 16,
  parameter int GAIN_W      = 6,
  parameter int ADDR_W      = 6,
  parameter int COMMIT_SYNC = 0,
  parameter int SNAP_TMO    = 65535
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     avs_readdatavalid,
  input  logic                     sync_in,
  input  logic [NCH*XY_W-1:0]      lia_x,
  input  logic [NCH*XY_W-1:0]      lia_y,
  input  logic [NCH-1:0]           lia_valid,
  output logic [NCH*PHASE_W-1:0]   phase_incr,
  output logic [NCH*PHASE_W-1:0]   phase_offs,
  output logic [GAIN_W-1:0]        gain_ctrl,
  output logic                     commit_pulse,
  output logic                     irq
);

  // Word map
  localparam int A_CTRL   = 0;
  localparam int A_STATUS = 1;
  localparam int A_GAIN   = 2;
  localparam int A_INCR   = 4;
  localparam int A_OFFS   = 4 + NCH;
  localparam int A_SNAP   = 4 + 2 * NCH;

  localparam int               TMO_W    = $clog2(SNAP_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(SNAP_TMO);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } snap_state_t;

  // --------------------------------------------------------------------------
  // Register storage
  // --------------------------------------------------------------------------
  logic [PHASE_W-1:0] shadow_incr [NCH];
  logic [PHASE_W-1:0] shadow_offs [NCH];
  logic [PHASE_W-1:0] active_incr [NCH];
  logic [PHASE_W-1:0] active_offs [NCH];
  logic [XY_W-1:0]    stage_x     [NCH];
  logic [XY_W-1:0]    stage_y     [NCH];
  logic [XY_W-1:0]    snap_x      [NCH];
  logic [XY_W-1:0]    snap_y      [NCH];

  logic [GAIN_W-1:0]  gain_reg;
  logic               irq_en;
  logic               commit_pending;
  logic               snap_done;
  logic               snap_tmo;
  logic               snap_busy;
  snap_state_t        state;
  logic [NCH-1:0]     got;
  logic [TMO_W-1:0]   tmo_cnt;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0]    addr;
  logic           wr_ctrl;
  logic           wr_status;
  logic           wr_gain;
  logic [NCH-1:0] wr_incr;
  logic [NCH-1:0] wr_offs;
  logic           commit_req;
  logic           arm_req;
  logic           commit_xfer;

  assign addr       = 32'(avs_address);
  assign wr_ctrl    = avs_write && (addr == 32'(A_CTRL));
  assign wr_status  = avs_write && (addr == 32'(A_STATUS));
  assign wr_gain    = avs_write && (addr == 32'(A_GAIN));
  assign commit_req = wr_ctrl && avs_writedata[0];
  assign arm_req    = wr_ctrl && avs_writedata[1];

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_dec
      assign wr_incr[k] = avs_write && (addr == 32'(A_INCR + k));
      assign wr_offs[k] = avs_write && (addr == 32'(A_OFFS + k));
    end
  endgenerate

  // Transfer condition: immediately after the request, or on the first
  // sync_in pulse seen while the request is outstanding.
  generate
    if (COMMIT_SYNC != 0) begin : g_commit_sync
      assign commit_xfer = commit_pending && sync_in;
    end else begin : g_commit_imm
      assign commit_xfer = commit_pending;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gain_ctrl = gain_reg;
  assign snap_busy = (state == ST_ARMED);

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_out
      assign phase_incr[k*PHASE_W +: PHASE_W] = active_incr[k];
      assign phase_offs[k*PHASE_W +: PHASE_W] = active_offs[k];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control, phase registers, commit and interrupt
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      gain_reg       <= '0;
      irq_en         <= 1'b0;
      commit_pending <= 1'b0;
      commit_pulse   <= 1'b0;
      irq            <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        shadow_incr[k] <= '0;
        shadow_offs[k] <= '0;
        active_incr[k] <= '0;
        active_offs[k] <= '0;
      end
    end else begin
      commit_pulse <= commit_xfer;
      // A new request in the transfer cycle stays pending for a later one;
      // a request while already pending simply merges.
      commit_pending <= (commit_pending && !commit_xfer) || commit_req;
      irq <= irq_en && (snap_done || snap_tmo);
      if (wr_ctrl) irq_en   <= avs_writedata[2];
      if (wr_gain) gain_reg <= avs_writedata[GAIN_W-1:0];
      for (int k = 0; k < NCH; k++) begin
        // The transfer uses the shadow values present before this edge.
        if (commit_xfer) begin
          active_incr[k] <= shadow_incr[k];
          active_offs[k] <= shadow_offs[k];
        end
        if (wr_incr[k]) shadow_incr[k] <= avs_writedata[PHASE_W-1:0];
        if (wr_offs[k]) shadow_offs[k] <= avs_writedata[PHASE_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Snapshot capture
  // --------------------------------------------------------------------------
  logic [NCH-1:0] hit;
  logic           complete;

  assign hit      = lia_valid & ~got;
  assign complete = &(got | lia_valid);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= ST_IDLE;
      got       <= '0;
      tmo_cnt   <= '0;
      snap_done <= 1'b0;
      snap_tmo  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        stage_x[k] <= '0;
        stage_y[k] <= '0;
        snap_x[k]  <= '0;
        snap_y[k]  <= '0;
      end
    end else begin
      // W1C first so that a set in the same cycle wins.
      if (wr_status && avs_writedata[2]) snap_done <= 1'b0;
      if (wr_status && avs_writedata[3]) snap_tmo  <= 1'b0;

      if (arm_req) begin
        state     <= ST_ARMED;
        got       <= '0;
        tmo_cnt   <= TMO_LOAD;
        snap_done <= 1'b0;
        snap_tmo  <= 1'b0;
      end else if (state == ST_ARMED) begin
        got <= got | lia_valid;
        for (int k = 0; k < NCH; k++) begin
          if (hit[k]) begin
            stage_x[k] <= lia_x[k*XY_W +: XY_W];
            stage_y[k] <= lia_y[k*XY_W +: XY_W];
          end
        end
        // Completion is tested before the timeout so a coincident last
        // strobe still completes. Channels arriving this cycle bypass the
        // staging registers.
        if (complete) begin
          for (int k = 0; k < NCH; k++) begin
            snap_x[k] <= got[k] ? stage_x[k] : lia_x[k*XY_W +: XY_W];
            snap_y[k] <= got[k] ? stage_y[k] : lia_y[k*XY_W +: XY_W];
          end
          snap_done <= 1'b1;
          state     <= ST_IDLE;
        end else if (tmo_cnt == TMO_ONE) begin
          snap_tmo <= 1'b1;
          state    <= ST_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt - TMO_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (addr == 32'(A_CTRL)) begin
      rd_mux = {29'd0, irq_en, 2'b00};
    end else if (addr == 32'(A_STATUS)) begin
      rd_mux = {28'd0, snap_tmo, snap_done, snap_busy, commit_pending};
    end else if (addr == 32'(A_GAIN)) begin
      rd_mux = 32'(gain_reg);
    end
    for (int k = 0; k < NCH; k++) begin
      if (addr == 32'(A_INCR + k)) rd_mux = 32'(shadow_incr[k]);
      if (addr == 32'(A_OFFS + k)) rd_mux = 32'(shadow_offs[k]);
      if (addr == 32'(A_SNAP + k)) begin
        rd_mux = {16'($signed(snap_y[k])), 16'($signed(snap_x[k]))};
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  // Upper write-data bits and sync_in are not needed in every configuration.
  logic unused_bits;
  assign unused_bits = ^{avs_writedata, sync_in};

endmodule
`default_nettype wire

// File: tb/tb_lia_multich_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_lia_multich_csr
// Purpose  : Randomised self-checking bench for lia_multich_csr. Two
//            instances share all inputs: u_imm commits immediately, u_sync
//            aligns commits to sync_in. Read responses go through a
//            scoreboard queue; other outputs are compared every cycle
//            against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lia_multich_csr;
  localparam int NCH = 8;
  localparam int PW  = 20;
  localparam int XW  = 12;
  localparam int GW  = 6;
  localparam int AW  = 6;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic reset_reset = 1'b1;
  logic [AW-1:0] avs_address = '0;
  logic avs_read = 1'b0, avs_write = 1'b0, sync_in = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [NCH*XW-1:0] lia_x = '0, lia_y = '0;
  logic [NCH-1:0] lia_valid = '0;

  logic [31:0] rdata1, rdata2;
  logic rdv1, rdv2, pulse1, pulse2, irq1, irq2;
  logic [NCH*PW-1:0] incr1, offs1, incr2, offs2;
  logic [GW-1:0] gain1, gain2;

  always #5 clk = ~clk;

  lia_multich_csr #(.NCH(NCH), .PHASE_W(PW), .XY_W(XW), .GAIN_W(GW), .ADDR_W(AW),
                    .COMMIT_SYNC(0), .SNAP_TMO(TMO)) u_imm (
    .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(rdata1), .avs_readdatavalid(rdv1), .sync_in(sync_in),
    .lia_x(lia_x), .lia_y(lia_y), .lia_valid(lia_valid),
    .phase_incr(incr1), .phase_offs(offs1), .gain_ctrl(gain1),
    .commit_pulse(pulse1), .irq(irq1));

  lia_multich_csr #(.NCH(NCH), .PHASE_W(PW), .XY_W(XW), .GAIN_W(GW), .ADDR_W(AW),
                    .COMMIT_SYNC(1), .SNAP_TMO(TMO)) u_sync (
    .clk_clk(clk), .reset_reset(reset_reset), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(rdata2), .avs_readdatavalid(rdv2), .sync_in(sync_in),
    .lia_x(lia_x), .lia_y(lia_y), .lia_valid(lia_valid),
    .phase_incr(incr2), .phase_offs(offs2), .gain_ctrl(gain2),
    .commit_pulse(pulse2), .irq(irq2));

  int n_chk = 0;
  int n_bad = 0;
  logic [63:0] rd_q[$];   // {expected u_sync, expected u_imm}

  // Behavioural model state
  logic [PW-1:0] m_sh_inc[NCH], m_sh_off[NCH];
  logic [PW-1:0] m_a1_inc[NCH], m_a1_off[NCH], m_a2_inc[NCH], m_a2_off[NCH];
  logic [XW-1:0] m_snx[NCH], m_sny[NCH], m_stx[NCH], m_sty[NCH];
  bit m_got[NCH];
  bit m_busy, m_done, m_tmo, m_pend1, m_pend2, m_pulse1, m_pulse2, m_irq, m_irq_en;
  logic [GW-1:0] m_gain;
  int m_elapsed;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int a, input bit second);
    logic [31:0] r;
    int k, sx, sy;
    r = '0;
    if (a == 0) r = {29'd0, m_irq_en, 2'b00};
    else if (a == 1) r = {28'd0, m_tmo, m_done, m_busy, second ? m_pend2 : m_pend1};
    else if (a == 2) r = 32'(m_gain);
    else if (a >= 4 && a < 4 + NCH) r = 32'(m_sh_inc[a-4]);
    else if (a >= 4 + NCH && a < 4 + 2*NCH) r = 32'(m_sh_off[a-4-NCH]);
    else if (a >= 4 + 2*NCH && a < 4 + 3*NCH) begin
      k = a - 4 - 2*NCH;
      sx = int'(m_snx[k]);
      sy = int'(m_sny[k]);
      if (sx >= 2**(XW-1)) sx = sx - 2**XW;
      if (sy >= 2**(XW-1)) sy = sy - 2**XW;
      r = {sy[15:0], sx[15:0]};
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_edge();
    int a;
    bit wr_commit, wr_arm, x1, x2, irq_nx, all_got;
    if (reset_reset) begin
      for (int k = 0; k < NCH; k++) begin
        m_sh_inc[k] = '0; m_sh_off[k] = '0; m_a1_inc[k] = '0; m_a1_off[k] = '0;
        m_a2_inc[k] = '0; m_a2_off[k] = '0; m_snx[k] = '0; m_sny[k] = '0;
        m_stx[k] = '0; m_sty[k] = '0; m_got[k] = 0;
      end
      {m_busy, m_done, m_tmo, m_pend1, m_pend2, m_pulse1, m_pulse2, m_irq, m_irq_en} = '0;
      m_gain = '0;
      m_elapsed = 0;
      return;
    end
    a = int'(avs_address);
    wr_commit = avs_write && a == 0 && avs_writedata[0];
    wr_arm    = avs_write && a == 0 && avs_writedata[1];
    irq_nx = m_irq_en && (m_done || m_tmo);
    x1 = m_pend1;
    x2 = m_pend2 && sync_in;
    for (int k = 0; k < NCH; k++) begin
      if (x1) begin m_a1_inc[k] = m_sh_inc[k]; m_a1_off[k] = m_sh_off[k]; end
      if (x2) begin m_a2_inc[k] = m_sh_inc[k]; m_a2_off[k] = m_sh_off[k]; end
    end
    m_pulse1 = x1;
    m_pulse2 = x2;
    m_pend1 = (m_pend1 && !x1) || wr_commit;
    m_pend2 = (m_pend2 && !x2) || wr_commit;
    if (avs_write && a == 1) begin
      if (avs_writedata[2]) m_done = 0;
      if (avs_writedata[3]) m_tmo = 0;
    end
    if (wr_arm) begin
      m_busy = 1; m_done = 0; m_tmo = 0; m_elapsed = 0;
      for (int k = 0; k < NCH; k++) m_got[k] = 0;
    end else if (m_busy) begin
      all_got = 1;
      for (int k = 0; k < NCH; k++) begin
        if (lia_valid[k] && !m_got[k]) begin
          m_got[k] = 1;
          m_stx[k] = lia_x[k*XW +: XW];
          m_sty[k] = lia_y[k*XW +: XW];
        end
        if (!m_got[k]) all_got = 0;
      end
      if (all_got) begin
        for (int k = 0; k < NCH; k++) begin m_snx[k] = m_stx[k]; m_sny[k] = m_sty[k]; end
        m_done = 1;
        m_busy = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == TMO) begin m_tmo = 1; m_busy = 0; end
      end
    end
    if (avs_write) begin
      if (a == 0) m_irq_en = avs_writedata[2];
      if (a == 2) m_gain = avs_writedata[GW-1:0];
      if (a >= 4 && a < 4 + NCH) m_sh_inc[a-4] = avs_writedata[PW-1:0];
      if (a >= 4 + NCH && a < 4 + 2*NCH) m_sh_off[a-4-NCH] = avs_writedata[PW-1:0];
    end
    m_irq = irq_nx;
  endtask

  task automatic check_outputs();
    logic [NCH*PW-1:0] e1i, e1o, e2i, e2o;
    for (int k = 0; k < NCH; k++) begin
      e1i[k*PW +: PW] = m_a1_inc[k]; e1o[k*PW +: PW] = m_a1_off[k];
      e2i[k*PW +: PW] = m_a2_inc[k]; e2o[k*PW +: PW] = m_a2_off[k];
    end
    chk("imm_phase_incr", incr1, e1i);
    chk("imm_phase_offs", offs1, e1o);
    chk("sync_phase_incr", incr2, e2i);
    chk("sync_phase_offs", offs2, e2o);
    chk("imm_commit_pulse", pulse1, m_pulse1);
    chk("sync_commit_pulse", pulse2, m_pulse2);
    chk("imm_gain_ctrl", gain1, m_gain);
    chk("sync_gain_ctrl", gain2, m_gain);
    chk("imm_irq", irq1, m_irq);
    chk("sync_irq", irq2, m_irq);
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    check_outputs();
  endtask

  // One cycle with the X/Y data already on the bus.
  task automatic cycle_raw(input bit w, input bit r, input int a,
                           input logic [31:0] d, input logic [NCH-1:0] m);
    avs_write = w; avs_read = r; avs_address = AW'(a); avs_writedata = d; lia_valid = m;
    if (r) rd_q.push_back({model_read(a, 1'b1), model_read(a, 1'b0)});
    step();
    avs_write = 1'b0; avs_read = 1'b0; lia_valid = '0;
  endtask

  task automatic cycle(input bit w, input bit r, input int a,
                       input logic [31:0] d, input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++) begin
      lia_x[k*XW +: XW] = XW'($urandom);
      lia_y[k*XW +: XW] = XW'($urandom);
    end
    cycle_raw(w, r, a, d, m);
  endtask

  task automatic wr(input int a, input logic [31:0] d); cycle(1, 0, a, d, '0); endtask
  task automatic rd(input int a); cycle(0, 1, a, '0, '0); endtask
  task automatic strobe(input logic [NCH-1:0] m); cycle(0, 0, 0, '0, m); endtask
  task automatic idle(input int n); repeat (n) cycle(0, 0, 0, '0, '0); endtask

  task automatic strobe_xy(input int k, input int x, input int y);
    lia_x[k*XW +: XW] = XW'(x);
    lia_y[k*XW +: XW] = XW'(y);
    cycle_raw(0, 0, 0, '0, NCH'(1) << k);
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    idle(2);
    reset_reset = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 4 + 3*NCH + 2; a++) rd(a);
    rd(63);
  endtask

  // Read-response monitor
  always @(posedge clk) begin
    logic [63:0] e;
    #2;
    chk("sync_readdatavalid", rdv2, rdv1);
    chk("readdatavalid", rdv1, rd_q.size() > 0);
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      if (rdv1) begin
        chk("imm_readdata", rdata1, e[31:0]);
        chk("sync_readdata", rdata2, e[63:32]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    // Reset state and read map
    do_reset();
    read_all();
    // Gain
    wr(2, 32'hFFFF_FFEA);
    rd(2);
    // Immediate commit of one channel; u_sync stays pending
    wr(4 + 3, 32'h0001_2345);
    wr(0, 32'h1);
    idle(2);
    rd(1);
    // Random shadow contents, merged commit requests
    for (int i = 0; i < 16; i++) wr($urandom_range(4, 4 + 2*NCH - 1), $urandom);
    wr(0, 32'h1);
    wr(0, 32'h1);
    idle(50);
    rd(1);
    sync_in = 1'b1; idle(1); sync_in = 1'b0;
    idle(2);
    rd(1);
    // Sync pulse in the cycle right after the commit write
    wr(4, 32'h000A_BCDE);
    wr(0, 32'h1);
    sync_in = 1'b1; idle(1); sync_in = 1'b0;
    idle(1);
    // Snapshot with duplicate channel-0 strobes
    wr(0, 32'h4);
    wr(0, 32'h6);
    for (int k = 0; k < NCH; k++) begin
      strobe_xy(k, k, -k);
      if (k % 2 == 1) strobe_xy(0, 12'h555, 12'h666);
    end
    idle(3);
    read_all();
    wr(1, 32'h4);
    idle(2);
    rd(1);
    // Timeout: channel 5 never strobes
    wr(0, 32'h6);
    for (int i = 0; i < 30; i++) strobe(NCH'($urandom) & ~(NCH'(1) << 5));
    idle(75);
    read_all();
    wr(1, 32'hC);
    idle(2);
    rd(1);
    // Last strobe coinciding with the timeout cycle
    wr(0, 32'h6);
    strobe(8'h7F);
    idle(98);
    strobe(8'h80);
    idle(2);
    read_all();
    // Re-arm mid-capture discards staging
    wr(0, 32'h6);
    strobe(8'h0F);
    wr(0, 32'h6);
    strobe(8'hF0);
    rd(1);
    strobe(8'h0F);
    idle(2);
    read_all();
    // Reset mid-capture
    wr(0, 32'h6);
    strobe(8'h07);
    rd(1);
    do_reset();
    rd(1);
    wr(0, 32'h2);
    strobe(8'hFF);
    read_all();
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      sync_in = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 9))
        0: cycle(1, 0, 0, $urandom, '0);
        1, 2: cycle(1, 0, $urandom_range(1, 31), $urandom, '0);
        3, 4, 5: cycle(0, 1, $urandom_range(0, 63), '0, NCH'($urandom));
        6: begin
          a = $urandom_range(0, 31);
          cycle(1, 1, a, $urandom, '0);
        end
        default: cycle(0, 0, 0, '0, NCH'($urandom));
      endcase
    end
    sync_in = 1'b0;
    read_all();
    idle(4);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
